// File: rtl/ip_wb_bridge_if.sv
// Bus bundle between the MEM/WB write-back stage, the bridge FIFO and the IP accelerator.
// The slave modport is the bridge view; the master modport is the pipeline/IP-side view.
interface ip_wb_bridge_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  logic                     wb_write;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;
  logic                     stall;
  logic                     ip_valid;
  logic [DATA_W-1:0]        ip_data;
  logic                     ip_last;
  logic                     ip_ready;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic [15:0]              burst_cnt;
  logic                     ovf;

  modport slave (
    input  wb_write, wb_data, flush, ip_ready,
    output stall, ip_valid, ip_data, ip_last, fifo_count, burst_cnt, ovf
  );

  modport master (
    output wb_write, wb_data, flush, ip_ready,
    input  stall, ip_valid, ip_data, ip_last, fifo_count, burst_cnt, ovf
  );
endinterface

// File: rtl/ip_wb_bridge.sv
// IP-mode write-back bridge: FIFO of retired words streamed to the IP in fixed bursts.
// Define IP_WB_OVF_DET_EN to latch a sticky ovf flag on a dropped push.
module ip_wb_bridge #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int AF_MARGIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  ip_wb_bridge_if.slave    bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic [15:0]       r_burst_cnt;
  logic              w_burst_done;
  logic              w_full, w_valid, w_push, w_pop, w_ovf;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_push  = bus.wb_write && !w_full && !bus.flush;
  assign w_pop   = w_valid && bus.ip_ready && !bus.flush;

  // Mem is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= bus.wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_burst_done) r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

  // With BURST_LEN==1 beat is always at its last value, so every pop completes a burst.
  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat;
    w_burst_done = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_beat_nxt  = '0;
    end else if (w_pop) begin
      if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
        w_state_nxt  = S_IDLE;
        w_beat_nxt   = '0;
        w_burst_done = 1'b1;
      end else begin
        w_state_nxt = S_BURST;
        w_beat_nxt  = r_beat + BEAT_W'(1);
      end
    end
  end

`ifdef IP_WB_OVF_DET_EN
  logic w_drop;
  logic r_ovf;
  assign w_drop = bus.wb_write && w_full && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end
  assign w_ovf = r_ovf;

`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && w_drop) $error("ip_wb_bridge: push dropped, FIFO full");
`endif
`else
  assign w_ovf = 1'b0;
`endif

  assign bus.stall      = (r_count >= CNT_W'(DEPTH - AF_MARGIN));
  assign bus.ip_valid   = w_valid;
  assign bus.ip_data    = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.ip_last    = w_valid && (r_beat == BEAT_W'(BURST_LEN - 1));
  assign bus.fifo_count = r_count;
  assign bus.burst_cnt  = r_burst_cnt;
  assign bus.ovf        = w_ovf;
endmodule
